// File: rtl/busca_prefetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch front end (master) and memory (slave).
interface busca_prefetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_dado;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_dado);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_dado);
endinterface

// File: rtl/busca_prefetch.sv
// Instruction-fetch front end with an in-order prefetch queue feeding IF/ID.
// Optional macro FETCH_BYPASS_EN: an acked word shows on the outputs in its ack cycle when the queue is empty.
module busca_prefetch #(
    parameter int unsigned PROF     = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  PCWrite,
    input  logic                  PCSrc,
    input  logic [31:0]           endereco_desvio,
    busca_prefetch_if.master      mem,
    output logic [31:0]           saidaMem,
    output logic [31:0]           saidaPC4,
    output logic                  instr_valida,
    output logic [$clog2(PROF):0] ocupacao
);
    localparam int unsigned PW = $clog2(PROF);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {OCIOSO, ESPERA, DESCARTE} estado_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entrada_t;

    estado_t       estado_q, estado_d;
    logic [31:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_pos_pop;
    logic          valid_q, valid_d;
    entrada_t      cabeca_q, cabeca_d;
    entrada_t      fila [PROF];

    logic          ack_espera, pop, push, consome;
    logic [31:0]   pc_mais4;
    entrada_t      entrada_nova;

    assign pc_mais4     = pc_q + 32'd4;
    assign entrada_nova = '{instr: mem.mem_dado, pc4: pc_mais4};
    assign ack_espera   = (estado_q == ESPERA) && mem.mem_ack;
    assign pop          = valid_q && PCWrite && !PCSrc;
    assign push         = ack_espera && !PCSrc && !consome;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    // Empty queue: the word arriving now is the head; if IF/ID takes it, it never enters the queue.
    assign bypass  = ack_espera && !PCSrc && (cnt_q == '0);
    assign consome = bypass && PCWrite;
`else
    assign consome = 1'b0;
`endif

    // Next-state, queue bookkeeping and next registered outputs.
    always_comb begin
        estado_d    = estado_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        rd_d        = rd_q + PW'(pop);
        wr_d        = wr_q + PW'(push);
        cnt_pos_pop = cnt_q - CW'(pop);
        cnt_d       = cnt_pos_pop + CW'(push);
        valid_d     = 1'b0;
        cabeca_d    = '{instr: NOP, pc4: 32'h0};

        if (PCSrc) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            pc_d  = endereco_desvio;
        end

        case (estado_q)
            OCIOSO: begin
                if (!PCSrc && (cnt_pos_pop < CW'(PROF))) begin
                    estado_d = ESPERA;
                    req_d    = 1'b1;
                    addr_d   = pc_q;
                end
            end
            ESPERA: begin
                if (mem.mem_ack) begin
                    if (!PCSrc) begin
                        pc_d = pc_mais4;
                    end
                    if (!PCSrc && (cnt_d < CW'(PROF))) begin
                        req_d  = 1'b1;
                        addr_d = pc_mais4;
                    end else begin
                        estado_d = OCIOSO;
                        req_d    = 1'b0;
                    end
                end else if (PCSrc) begin
                    estado_d = DESCARTE;
                end
            end
            DESCARTE: begin
                // Stale request completes; its data is dropped, the redirect target is kept in pc.
                if (mem.mem_ack) begin
                    estado_d = OCIOSO;
                    req_d    = 1'b0;
                end
            end
            default: begin
                estado_d = OCIOSO;
                req_d    = 1'b0;
            end
        endcase

        valid_d = (cnt_d != '0);
        if (valid_d) begin
            if (push && (cnt_pos_pop == '0)) begin
                cabeca_d = entrada_nova;
            end else begin
                cabeca_d = fila[rd_d];
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            cabeca_q <= '{instr: NOP, pc4: 32'h0};
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            cabeca_q <= cabeca_d;
        end
    end

    // Queue storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            fila[wr_q] <= entrada_nova;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign ocupacao     = cnt_q;

`ifdef FETCH_BYPASS_EN
    assign instr_valida = valid_q || bypass;
    assign saidaMem     = bypass ? mem.mem_dado : cabeca_q.instr;
    assign saidaPC4     = bypass ? pc_mais4     : cabeca_q.pc4;
`else
    assign instr_valida = valid_q;
    assign saidaMem     = cabeca_q.instr;
    assign saidaPC4     = cabeca_q.pc4;
`endif

endmodule

// File: tb/tb_busca_prefetch.sv
// Self-checking bench for busca_prefetch: directed steps, a memory responder and a scoreboard queue.
`timescale 1ns/1ps
module tb_busca_prefetch;
    localparam int unsigned PROF     = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic                  clock;
    logic                  reset_n;
    logic                  PCWrite;
    logic                  PCSrc;
    logic [31:0]           endereco_desvio;
    logic [31:0]           saidaMem;
    logic [31:0]           saidaPC4;
    logic                  instr_valida;
    logic [$clog2(PROF):0] ocupacao;

    busca_prefetch_if bus ();

    busca_prefetch #(.PROF(PROF), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .PCWrite         (PCWrite),
        .PCSrc           (PCSrc),
        .endereco_desvio (endereco_desvio),
        .mem             (bus),
        .saidaMem        (saidaMem),
        .saidaPC4        (saidaPC4),
        .instr_valida    (instr_valida),
        .ocupacao        (ocupacao)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int          errors, checks;
    ent_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_pc, prev_addr;
    bit          discard, prev_pend, model_on, tie_ack;
    int          age, lat;
    bit          cap_valid;
    logic [31:0] cap_mem;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_000C: return 32'h8C01_0000;
            32'h0000_0040: return 32'h2002_0005;
            default:       return 32'hE000_0000 ^ a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One clock cycle: memory response, scoreboard checks, model update, edge.
    task automatic cyc();
        bit   ack, byp, vexp;
        ent_t head, e;
        ack          = bus.mem_req && (tie_ack || (age >= lat - 1));
        bus.mem_ack  = tie_ack ? 1'b1 : ack;
        bus.mem_dado = ack ? mem_word(bus.mem_addr) : 32'hDEAD_BEEF;
        #1;
        byp  = BYP && ack && !discard && !PCSrc && (exp_q.size() == 0);
        vexp = (exp_q.size() != 0) || byp;
        if (byp) begin
            head.instr = mem_word(bus.mem_addr);
            head.pc4   = bus.mem_addr + 32'd4;
        end else if (exp_q.size() != 0) begin
            head = exp_q[0];
        end else begin
            head.instr = NOP;
            head.pc4   = 32'h0;
        end
        if (model_on) begin
            if (prev_pend) begin
                chk("req_hold", 32'(bus.mem_req), 32'd1);
                chk("addr_hold", bus.mem_addr, prev_addr);
            end else if (bus.mem_req) begin
                chk("req_addr", bus.mem_addr, exp_pc);
                req_log.push_back(bus.mem_addr);
            end
            chk("ocupacao", 32'(ocupacao), 32'(exp_q.size()));
            chk("instr_valida", 32'(instr_valida), 32'(vexp));
            chk("saidaMem", saidaMem, head.instr);
            chk("saidaPC4", saidaPC4, head.pc4);
        end
        cap_valid = instr_valida;
        cap_mem   = saidaMem;
        if (instr_valida && PCWrite && !PCSrc) pop_log.push_back(saidaPC4);

        if (vexp && PCWrite && !PCSrc && !byp) void'(exp_q.pop_front());
        if (ack && !discard && !PCSrc && !(byp && PCWrite)) begin
            e.instr = mem_word(bus.mem_addr);
            e.pc4   = bus.mem_addr + 32'd4;
            exp_q.push_back(e);
        end
        if (PCSrc) begin
            exp_q.delete();
            exp_pc = endereco_desvio;
        end else if (ack && !discard) begin
            exp_pc = exp_pc + 32'd4;
        end
        if (ack) discard = 1'b0;
        else if (PCSrc && bus.mem_req) discard = 1'b1;
        prev_pend = bus.mem_req && !ack;
        prev_addr = bus.mem_addr;
        if (!bus.mem_req || ack) age = 0;
        else age++;
        if (!reset_n) begin
            exp_q.delete();
            exp_pc    = RESET_PC;
            discard   = 1'b0;
            prev_pend = 1'b0;
            age       = 0;
            model_on  = 1'b1;
        end
        @(posedge clock);
        #1;
        bus.mem_ack = tie_ack;
    endtask

    initial begin
        bit found;
        errors = 0; checks = 0; model_on = 1'b0; tie_ack = 1'b0; lat = 1; age = 0;
        discard = 1'b0; prev_pend = 1'b0; exp_pc = RESET_PC; prev_addr = '0;
        reset_n = 1'b0; PCWrite = 1'b0; PCSrc = 1'b0; endereco_desvio = '0;
        bus.mem_ack = 1'b0; bus.mem_dado = '0;
        @(posedge clock); #1;

        // Reset with ack tied high, then fill the queue under stall.
        tie_ack = 1'b1;
        cyc(); cyc();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valida), 32'd0);
        chk("rst_saidaMem", saidaMem, NOP);
        chk("rst_saidaPC4", saidaPC4, 32'h0);
        chk("rst_ocupacao", 32'(ocupacao), 32'd0);
        reset_n = 1'b1;
        req_log.delete();
        repeat (10) cyc();
        chk("fill_nreq", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++) chk("fill_addr", req_log[i], 32'(4 * i));
        chk("full_ocupacao", 32'(ocupacao), 32'(PROF));
        chk("full_no_req", 32'(bus.mem_req), 32'd0);

        // Pop three, then stall five cycles on the 0xC entry.
        PCWrite = 1'b1;
        repeat (3) cyc();
        PCWrite = 1'b0;
        repeat (5) begin
            chk("stall_mem", saidaMem, 32'h8C01_0000);
            chk("stall_pc4", saidaPC4, 32'h0000_0010);
            cyc();
        end
        PCWrite = 1'b1;
        cyc();
        PCWrite = 1'b0;
        chk("after_stall_pc4", saidaPC4, 32'h0000_0014);
        chk("after_stall_mem", saidaMem, mem_word(32'h10));

        // Latency 3, PCWrite held high.
        tie_ack = 1'b0; lat = 3; reset_n = 1'b0;
        cyc();
        reset_n = 1'b1; PCWrite = 1'b1;
        pop_log.delete();
        for (int i = 0; i < 60 && pop_log.size() < 3; i++) cyc();
        chk("lat3_npop", 32'(pop_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < pop_log.size(); i++) chk("lat3_pc4", pop_log[i], 32'(4 * (i + 1)));

        // Redirect while the request to 0x14 is outstanding.
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.mem_req && bus.mem_addr == 32'h14 && age == 0) begin found = 1'b1; break; end
            cyc();
        end
        chk("wait_req_14", 32'(found), 32'd1);
        PCSrc = 1'b1; endereco_desvio = 32'h40;
        cyc();
        PCSrc = 1'b0;
        chk("redir_ocupacao", 32'(ocupacao), 32'd0);
        chk("redir_valid", 32'(instr_valida), 32'd0);
        chk("redir_stale_req", bus.mem_addr, 32'h14);
        req_log.delete(); pop_log.delete();
        for (int i = 0; i < 40 && pop_log.size() < 1; i++) cyc();
        chk("redir_npop", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) chk("redir_first_pc4", pop_log[0], 32'h44);
        if (req_log.size() > 0) chk("redir_first_req", req_log[0], 32'h40);
        else chk("redir_first_req", 32'hFFFF_FFFF, 32'h40);

        // Redirect in the same cycle as an ack.
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_req && age == lat - 1) begin found = 1'b1; break; end
            cyc();
        end
        chk("wait_ack", 32'(found), 32'd1);
        PCSrc = 1'b1; endereco_desvio = 32'h80;
        cyc();
        PCSrc = 1'b0;
        chk("simul_ocupacao", 32'(ocupacao), 32'd0);
        chk("simul_valid", 32'(instr_valida), 32'd0);
        req_log.delete(); pop_log.delete();
        for (int i = 0; i < 40 && pop_log.size() < 1; i++) cyc();
        if (req_log.size() > 0) chk("simul_first_req", req_log[0], 32'h80);
        else chk("simul_first_req", 32'hFFFF_FFFF, 32'h80);
        if (pop_log.size() > 0) chk("simul_first_pc4", pop_log[0], 32'h84);
        else chk("simul_first_pc4", 32'hFFFF_FFFF, 32'h84);

        // Reset while a request is outstanding and acked in the same cycle.
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_req && age == 0) begin found = 1'b1; break; end
            cyc();
        end
        chk("wait_req_rst", 32'(found), 32'd1);
        reset_n = 1'b0; tie_ack = 1'b1;
        cyc();
        reset_n = 1'b1; tie_ack = 1'b0; bus.mem_ack = 1'b0;
        chk("rst2_mem_addr", bus.mem_addr, RESET_PC);
        chk("rst2_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst2_valid", 32'(instr_valida), 32'd0);
        chk("rst2_ocupacao", 32'(ocupacao), 32'd0);

        // Empty queue, ack of 0x20020005 with PCWrite high.
        lat = 2; PCWrite = 1'b1;
        PCSrc = 1'b1; endereco_desvio = 32'h40;
        cyc();
        PCSrc = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req && age == lat - 1) begin found = 1'b1; break; end
            cyc();
        end
        chk("wait_byp_ack", 32'(found), 32'd1);
        pop_log.delete();
        cyc();
        chk("byp_valid", 32'(cap_valid), 32'(BYP));
        chk("byp_mem", cap_mem, BYP ? 32'h2002_0005 : NOP);
        chk("byp_ocupacao", 32'(ocupacao), BYP ? 32'd0 : 32'd1);
        cyc();
        if (pop_log.size() > 0) chk("byp_first_pc4", pop_log[0], 32'h44);
        else chk("byp_first_pc4", 32'hFFFF_FFFF, 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
